// File: rtl/group_accum.sv
// Reduces up to GROUP input beats into one result (running sum or running max of
// per-beat lane sums) and holds it in a single valid/ready output register.
module group_accum #(
  parameter int N_LANE = 2,
  parameter int IW     = 4,
  parameter int GROUP  = 3,
  parameter int OW     = IW + $clog2(N_LANE) + $clog2(GROUP),
  parameter int MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [IW-1:0]                i [N_LANE],
  input  logic                         i_last,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [OW-1:0]                o,
  output logic [$clog2(GROUP+1)-1:0]   o_cnt
);

  localparam int CW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int KW = $clog2(GROUP + 1);

  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_o;
  logic [KW-1:0] r_ocnt;
  logic          r_ovalid;

  logic [OW-1:0] w_beat;
  logic [OW-1:0] w_acc_next;
  logic [KW-1:0] w_cnt_inc;
  logic          w_accept;
  logic          w_close;

  // Handshake: a beat transfers on a rising clk edge when i_valid && i_ready, a
  // result transfers when o_valid && o_ready. i_ready looks only at the output
  // register, so a held result can drain while a new group closes on the same edge.
  assign i_ready  = !r_ovalid || o_ready;
  assign w_accept = i_valid && i_ready;

  // Adding in OW bits wraps exactly like truncating the full-width lane sum.
  always_comb begin
    w_beat = '0;
    for (int k = 0; k < N_LANE; k++) begin
      w_beat = w_beat + OW'(i[k]);
    end
  end

  always_comb begin
    w_acc_next = w_beat;
    if (r_cnt != '0) begin
      if (MODE == 0) begin
        w_acc_next = r_acc + w_beat;
      end else begin
        w_acc_next = (w_beat > r_acc) ? w_beat : r_acc;
      end
    end
  end

  assign w_close   = w_accept && (i_last || (r_cnt == CW'(GROUP - 1)));
  assign w_cnt_inc = KW'(r_cnt) + KW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_o      <= '0;
      r_ocnt   <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= w_close ? '0 : r_cnt + CW'(1);
      end
      if (w_close) begin
        r_o      <= w_acc_next;
        r_ocnt   <= w_cnt_inc;
        r_ovalid <= 1'b1;
      end else if (o_ready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  assign o_valid = r_ovalid;
  assign o       = r_o;
  assign o_cnt   = r_ocnt;

endmodule

// File: tb/tb_group_accum.sv
// Four group_accum configurations share one stimulus stream; a group-level model
// predicts results into per-instance queues that a negedge monitor drains.
module tb_group_accum;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [3:0] lanes [2];

  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic       ov_a, ov_b, ov_c, ov_d;
  logic [6:0] o_a;
  logic [4:0] o_b;
  logic [6:0] o_c;
  logic [3:0] o_d;
  logic [1:0] cnt_a;
  logic [0:0] cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] cnt_d;

  // a: defaults, b: GROUP=1, c: MODE=1, d: OW=4
  group_accum u_a (.clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy_a), .i(lanes),
                   .i_last(i_last), .o_valid(ov_a), .o_ready(o_ready), .o(o_a), .o_cnt(cnt_a));
  group_accum #(.GROUP(1)) u_b (.clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy_b),
                   .i(lanes), .i_last(i_last), .o_valid(ov_b), .o_ready(o_ready), .o(o_b), .o_cnt(cnt_b));
  group_accum #(.MODE(1)) u_c (.clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy_c),
                   .i(lanes), .i_last(i_last), .o_valid(ov_c), .o_ready(o_ready), .o(o_c), .o_cnt(cnt_c));
  group_accum #(.OW(4)) u_d (.clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(rdy_d),
                   .i(lanes), .i_last(i_last), .o_valid(ov_d), .o_ready(o_ready), .o(o_d), .o_cnt(cnt_d));

  int p_group [4] = '{3, 1, 3, 3};
  int p_mode  [4] = '{0, 0, 1, 0};
  int p_ow    [4] = '{7, 5, 7, 4};

  int got_o [4];
  int got_cnt [4];
  int got_v [4];
  int got_rdy [4];

  always_comb begin
    got_o[0] = int'(o_a);   got_o[1] = int'(o_b);   got_o[2] = int'(o_c);   got_o[3] = int'(o_d);
    got_cnt[0] = int'(cnt_a); got_cnt[1] = int'(cnt_b); got_cnt[2] = int'(cnt_c); got_cnt[3] = int'(cnt_d);
    got_v[0] = int'(ov_a);  got_v[1] = int'(ov_b);  got_v[2] = int'(ov_c);  got_v[3] = int'(ov_d);
    got_rdy[0] = int'(rdy_a); got_rdy[1] = int'(rdy_b); got_rdy[2] = int'(rdy_c); got_rdy[3] = int'(rdy_d);
  end

  // Expected results packed as {cnt[3:0], o[11:0]}.
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  logic [15:0] exp_q3[$];

  bit m_pend [4];
  int grp_n [4];
  int grp_sum [4];
  int grp_max [4];
  int last_o [4];
  int last_cnt [4];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, k, got, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic logic [15:0] q_front(input int k);
    case (k)
      0: return exp_q0[0];
      1: return exp_q1[0];
      2: return exp_q2[0];
      default: return exp_q3[0];
    endcase
  endfunction

  task automatic q_push(input int k, input logic [15:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: exp_q2.push_back(v);
      default: exp_q3.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k);
    case (k)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      2: void'(exp_q2.pop_front());
      default: void'(exp_q3.pop_front());
    endcase
  endtask

  // Group-level reference: collects beat sums of the open group, reduces at close.
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      bit acc_b;
      int beat;
      int res;
      acc_b = i_valid && (!m_pend[k] || o_ready);
      if (m_pend[k] && o_ready) m_pend[k] = 1'b0;
      if (acc_b) begin
        beat = (int'(lanes[0]) + int'(lanes[1])) % (1 << p_ow[k]);
        grp_n[k]++;
        grp_sum[k] += beat;
        if (grp_n[k] == 1 || beat > grp_max[k]) grp_max[k] = beat;
        if (i_last || grp_n[k] == p_group[k]) begin
          res = (p_mode[k] == 1) ? grp_max[k] : grp_sum[k] % (1 << p_ow[k]);
          q_push(k, {4'(grp_n[k]), 12'(res)});
          m_pend[k] = 1'b1;
          grp_n[k] = 0;
          grp_sum[k] = 0;
          grp_max[k] = 0;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit v, input int a, input int b, input bit last);
    i_valid  = v;
    lanes[0] = 4'(a);
    lanes[1] = 4'(b);
    i_last   = last;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_last  = 1'b0;
    rst     = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk("rst_o_valid", k, got_v[k], 0);
      chk("rst_o", k, got_o[k], 0);
      chk("rst_o_cnt", k, got_cnt[k], 0);
      chk("rst_i_ready", k, got_rdy[k], 1);
      m_pend[k] = 1'b0;
      grp_n[k] = 0;
      grp_sum[k] = 0;
      grp_max[k] = 0;
      last_o[k] = -1;
      last_cnt[k] = -1;
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_q3.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: compares every presented result against the front of its queue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        chk("i_ready", k, got_rdy[k], (!m_pend[k] || o_ready) ? 1 : 0);
        chk("o_valid", k, got_v[k], m_pend[k] ? 1 : 0);
        if (got_v[k] != 0) begin
          if (q_size(k) == 0) begin
            chk("spurious_o_valid", k, 1, 0);
          end else begin
            e = q_front(k);
            chk("o", k, got_o[k], int'(e[11:0]));
            chk("o_cnt", k, got_cnt[k], int'(e[15:12]));
            if (o_ready) begin
              q_pop(k);
              last_o[k] = got_o[k];
              last_cnt[k] = got_cnt[k];
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    o_ready = 1'b1;
    lanes[0] = '0;
    lanes[1] = '0;
    @(posedge clk);
    #1;

    // Full group
    do_reset();
    cycle(1, 1, 2, 0); cycle(1, 3, 4, 0); cycle(1, 5, 6, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    chk("full_o", 0, last_o[0], 21);
    chk("full_cnt", 0, last_cnt[0], 3);
    chk("full_o_ow4", 3, last_o[3], 5);
    chk("full_o_g1", 1, last_o[1], 11);

    // Early close, then a fresh full group
    do_reset();
    cycle(1, 15, 15, 0); cycle(1, 15, 15, 1);
    cycle(0, 0, 0, 0);
    chk("early_o", 0, last_o[0], 60);
    chk("early_cnt", 0, last_cnt[0], 2);
    cycle(1, 1, 2, 0); cycle(1, 3, 4, 0); cycle(1, 5, 6, 0);
    cycle(0, 0, 0, 0);
    chk("after_early_o", 0, last_o[0], 21);
    chk("after_early_cnt", 0, last_cnt[0], 3);

    // Backpressure
    do_reset();
    o_ready = 1'b0;
    cycle(1, 1, 2, 0); cycle(1, 3, 4, 0); cycle(1, 5, 6, 0);
    cycle(1, 1, 1, 0); cycle(1, 1, 1, 0);
    chk("bp_hold_o", 0, got_o[0], 21);
    chk("bp_hold_ready", 0, got_rdy[0], 0);
    o_ready = 1'b1;
    #1;
    chk("bp_release_ready", 0, got_rdy[0], 1);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    chk("bp_drained_o", 0, last_o[0], 21);

    // Back-to-back with GROUP=1
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      cycle(1, n, n, 0);
      chk("b2b_o", 1, got_o[1], 2 * n);
      chk("b2b_o_valid", 1, got_v[1], 1);
    end
    cycle(0, 0, 0, 0);

    // Max mode, and narrow output wrap
    do_reset();
    cycle(1, 1, 2, 0); cycle(1, 5, 6, 0); cycle(1, 3, 4, 0);
    cycle(0, 0, 0, 0);
    chk("max_o", 2, last_o[2], 11);
    chk("max_cnt", 2, last_cnt[2], 3);
    do_reset();
    cycle(1, 15, 15, 0); cycle(1, 15, 15, 0); cycle(1, 15, 15, 0);
    cycle(0, 0, 0, 0);
    chk("wrap_o", 3, last_o[3], 10);

    // Reset mid-group discards the partial group
    do_reset();
    cycle(1, 1, 1, 0); cycle(1, 1, 1, 0);
    do_reset();
    cycle(1, 1, 2, 0); cycle(1, 3, 4, 0); cycle(1, 5, 6, 0);
    cycle(0, 0, 0, 0);
    chk("rst_mid_o", 0, last_o[0], 21);
    chk("rst_mid_cnt", 0, last_cnt[0], 3);

    // Randomized traffic with backpressure and occasional reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      o_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 3) == 0);
      end
    end

    o_ready = 1'b1;
    repeat (4) cycle(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) chk("leftover_results", k, q_size(k), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/group_accum.md
GROUP_ACCUM -- requirements
Module: group_accum

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_LANE, 2: input lanes per beat
- IW, 4: lane width in bits
- GROUP, 3: beats per full group (>=1)
- OW, IW+$clog2(N_LANE)+$clog2(GROUP): output width
- MODE, 0: 0 = sum of beat-sums, 1 = max of beat-sums
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock
- rst, in, 1: reset, asynchronous, active-low
- i_valid, in, 1: input beat valid
- i_ready, out, 1: block accepts beat
- i, in, IW x [N_LANE]: unpacked lane array, unsigned
- i_last, in, 1: closes current group early (qualified by accept)
- o_valid, out, 1: result valid
- o_ready, in, 1: downstream accepts result
- o, out, OW: group result
- o_cnt, out, $clog2(GROUP+1): beats contained in result

Function
REQ-003 Input accept SHALL occur exactly when i_valid && i_ready at a rising clk edge.
REQ-004 i_ready SHALL equal !o_valid || o_ready; it SHALL be combinational and SHALL NOT depend on i_valid.
REQ-005 Beat-sum SHALL be the unsigned sum of all N_LANE lanes, zero-extended before addition, then truncated to OW.
REQ-006 On the first accepted beat of a group, the accumulator SHALL load the beat-sum; on later beats it SHALL take acc+beat-sum mod 2^OW (MODE 0) or max(acc, beat-sum) (MODE 1).
REQ-007 Beat counter SHALL run 0..GROUP-1 and count accepted beats only; idle cycles SHALL hold accumulator and counter.
REQ-008 A group SHALL close on the accepted beat where counter==GROUP-1 or i_last==1, whichever comes first; i_last on the first beat SHALL give a one-beat group.
REQ-009 On close, the next cycle SHALL show o_valid=1, o = final accumulator value including the closing beat, and o_cnt = beats in the group (1..GROUP); the counter SHALL return to 0.
REQ-010 Result latency SHALL be exactly 1 cycle from the closing accept to o_valid.
REQ-011 While o_valid && !o_ready, o, o_cnt and o_valid SHALL stay stable.
REQ-012 o_valid SHALL clear on the cycle after o_valid && o_ready, unless a new group closes on that same edge; in that case o_valid SHALL remain 1 with the new result (back-to-back, no bubble).
REQ-013 i_valid with i_ready=0 SHALL NOT alter any state.
REQ-014 GROUP=1 SHALL make every accepted beat a group with o_cnt=1.

Reset
REQ-015 While rst=0, the block SHALL asynchronously clear o_valid=0, o=0, o_cnt=0, accumulator=0 and counter=0; i_ready SHALL read 1.
REQ-016 Reset asserted mid-group SHALL discard the partial group; the first beat accepted after release SHALL start a new group.

Verification
REQ-017 The bench SHALL cover these directed scenarios (defaults unless stated):
- Full group: beats (1,2),(3,4),(5,6), o_ready=1 -> o=21, o_cnt=3, o_valid for 1 cycle, 1 cycle after third beat.
- Early close: (15,15),(15,15)+i_last -> o=60, o_cnt=2; next group counts from 0.
- Backpressure: o_ready=0 after result 21 -> o held at 21, i_ready=0, next beats not accepted; o_ready=1 -> i_ready=1 in the same cycle.
- Back-to-back: GROUP=1, continuous beats (1,1),(2,2),(3,3), o_ready=1 -> o=2,4,6 on consecutive cycles, o_valid constantly 1.
- MODE=1: beats (1,2),(5,6),(3,4) -> o=11, o_cnt=3; OW=4 MODE=0, (15,15)x3 -> o=90 mod 16=10.
- Reset mid-group: 2 beats of (1,1), rst pulse, then (1,2),(3,4),(5,6) -> o=21, o_cnt=3, no stale result.
